// File: rtl/alu_wide_sequencer.sv
// Purpose: runs one 2*SLICE_W-wide ALU operation as a low-slice then a high-slice micro-op on a narrow ALU.
// Latency: with a zero-wait ALU, rsp_valid is high in the 5th cycle after the request is accepted (one cycle per state).
// Backpressure: one op in flight; req_ready only in IDLE; micro-op held while alu_ready=0; result held while rsp_ready=0.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   req_valid/req_ready   - wide request handshake; req_op, req_a, req_b carry the operation
//   alu_valid/alu_ready   - slice micro-op handshake; alu_op, alu_a, alu_b, alu_cin carry the micro-op
//   alu_rsp_valid         - one-cycle slice result pulse with alu_result, alu_cout
//   rsp_valid/rsp_ready   - wide result handshake; rsp_result, rsp_cout carry the result
//   op_count              - completed-operation counter (wraps); proto_err - sticky unexpected-response flag
module alu_wide_sequencer #(
    parameter int SLICE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [2*SLICE_W-1:0]   req_a,
    input  logic [2*SLICE_W-1:0]   req_b,
    output logic                   alu_valid,
    input  logic                   alu_ready,
    output logic [1:0]             alu_op,
    output logic [SLICE_W-1:0]     alu_a,
    output logic [SLICE_W-1:0]     alu_b,
    output logic                   alu_cin,
    input  logic                   alu_rsp_valid,
    input  logic [SLICE_W-1:0]     alu_result,
    input  logic                   alu_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*SLICE_W-1:0]   rsp_result,
    output logic                   rsp_cout,
    output logic [7:0]             op_count,
    output logic                   proto_err
);

    localparam int W = 2 * SLICE_W;

    localparam logic [1:0] OP_ADDU = 2'd0;
    localparam logic [1:0] OP_SUBU = 2'd1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        WAIT_LO  = 3'd2,
        ISSUE_HI = 3'd3,
        WAIT_HI  = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t              state;
    state_t              nextState;

    logic [1:0]          opReg;
    logic [W-1:0]        aReg;
    logic [W-1:0]        bReg;
    logic [SLICE_W-1:0]  loResult;
    logic [SLICE_W-1:0]  hiResult;
    logic                carryReg;
    logic                coutReg;
    logic [7:0]          opCount;
    logic                protoErr;
    logic                isArith;
    logic                inWait;

    // Only ADDU/SUBU propagate the low-slice carry; logic ops run each slice independently.
    assign isArith = (opReg == OP_ADDU) || (opReg == OP_SUBU);
    assign inWait  = (state == WAIT_LO) || (state == WAIT_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        req_ready = 1'b0;
        alu_valid = 1'b0;
        alu_a     = aReg[SLICE_W-1:0];
        alu_b     = bReg[SLICE_W-1:0];
        alu_cin   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = ISSUE_LO;
                end
            end
            ISSUE_LO: begin
                alu_valid = 1'b1;
                // SUBU is a + ~b + 1: the "+1" enters as the low-slice carry-in.
                alu_cin   = (opReg == OP_SUBU);
                if (alu_ready) begin
                    nextState = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (alu_rsp_valid) begin
                    nextState = ISSUE_HI;
                end
            end
            ISSUE_HI: begin
                alu_valid = 1'b1;
                alu_a     = aReg[W-1:SLICE_W];
                alu_b     = bReg[W-1:SLICE_W];
                alu_cin   = isArith & carryReg;
                if (alu_ready) begin
                    nextState = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (alu_rsp_valid) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opReg    <= '0;
            aReg     <= '0;
            bReg     <= '0;
            loResult <= '0;
            hiResult <= '0;
            carryReg <= 1'b0;
            coutReg  <= 1'b0;
            opCount  <= '0;
            protoErr <= 1'b0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                opReg <= req_op;
                aReg  <= req_a;
                bReg  <= req_b;
            end
            if ((state == WAIT_LO) && alu_rsp_valid) begin
                loResult <= alu_result;
                carryReg <= alu_cout;
            end
            if ((state == WAIT_HI) && alu_rsp_valid) begin
                hiResult <= alu_result;
                coutReg  <= alu_cout;
            end
            if ((state == RESP) && rsp_ready) begin
                opCount <= opCount + 8'd1;
            end
            // A slice result outside a wait state has no owner; flag it and keep the data path untouched.
            if (alu_rsp_valid && !inWait) begin
                protoErr <= 1'b1;
            end
        end
    end

    // alu_a/alu_b/alu_op come straight from the request registers, so they cannot move while a micro-op stalls.
    assign alu_op     = opReg;
    assign rsp_result = {hiResult, loResult};
    assign rsp_cout   = coutReg;
    assign op_count   = opCount;
    assign proto_err  = protoErr;

endmodule

// File: doc/alu_wide_sequencer.md
ALU_WIDE_SEQUENCER -- requirements
Module: alu_wide_sequencer

Interface
REQ-001 Parameter: SLICE_W, 8, width of one ALU slice; request/response width is 2*SLICE_W (16 by default).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  wide-operation request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_op  input  2  op_mne code: ADDU=0, SUBU=1, AND=2, XOR=3.
REQ-007 req_a, req_b  input  2*SLICE_W  wide operands.
REQ-008 alu_valid  output  1  slice micro-op offered to the ALU.
REQ-009 alu_ready  input  1  ALU accepts the micro-op.
REQ-010 alu_op  output  2  op_mne code for the slice.
REQ-011 alu_a, alu_b  output  SLICE_W  slice operands.
REQ-012 alu_cin  output  1  slice carry-in.
REQ-013 alu_rsp_valid  input  1  ALU slice result present (one-cycle pulse).
REQ-014 alu_result  input  SLICE_W  slice result; alu_cout  input  1  slice carry-out.
REQ-015 rsp_valid  output  1  wide result available; rsp_ready  input  1  consumer takes it.
REQ-016 rsp_result  output  2*SLICE_W  wide result; rsp_cout  output  1  carry-out of the high slice.
REQ-017 op_count  output  8  completed-operation counter; proto_err  output  1  sticky protocol error flag.

Function
REQ-018 The FSM SHALL use the states IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI and RESP.
REQ-019 IDLE: req_ready=1; on req_valid, latch op/a/b and move to ISSUE_LO; req_ready SHALL be 0 in every other state.
REQ-020 ISSUE_LO: alu_valid=1, alu_a/alu_b=low slices; alu_cin=1 for SUBU, else 0; on alu_ready move to WAIT_LO.
REQ-021 WAIT_LO: on alu_rsp_valid, latch alu_result into the low result and alu_cout into the carry register; move to ISSUE_HI.
REQ-022 ISSUE_HI: alu_valid=1, high slices; alu_cin=latched low carry for ADDU/SUBU, 0 for AND/XOR; on alu_ready move to WAIT_HI.
REQ-023 WAIT_HI: on alu_rsp_valid, latch the high result and rsp_cout; move to RESP.
REQ-024 RESP: rsp_valid=1 with stable rsp_result/rsp_cout; on rsp_ready, op_count increments (wraps 0xFF->0x00) and the FSM returns to IDLE.
REQ-025 SUBU SHALL compute a + ~b + 1 across both slices, so rsp_cout=1 means no borrow; ALU slices treat SUBU as a + ~b + cin.
REQ-026 alu_op, alu_a, alu_b and alu_cin SHALL be held stable while alu_valid=1 and alu_ready=0.
REQ-027 alu_valid SHALL be 0 in IDLE, WAIT_LO, WAIT_HI and RESP.
REQ-028 alu_rsp_valid in any state other than WAIT_LO/WAIT_HI SHALL be ignored for data and SHALL set proto_err, which holds until reset.
REQ-029 With alu_ready=1 and alu_rsp_valid on the cycle after issue, rsp_valid SHALL rise 5 cycles after the request-accept edge.
REQ-030 No new request SHALL be accepted in the cycle where RESP completes; the earliest next accept is the following cycle, in IDLE.

Reset
REQ-031 While reset=1 at a clock edge: FSM->IDLE; req_ready=1 after the edge; alu_valid=0, rsp_valid=0, alu_op=0, alu_a=alu_b=0, alu_cin=0, rsp_result=0, rsp_cout=0, op_count=0, proto_err=0.
REQ-032 Reset SHALL take priority over all other events in every state; an in-flight operation is discarded without a response.

Verification
REQ-033 ADDU 0x00FF+0x0001, zero-wait ALU -> hi slice issued with alu_cin=1; rsp_result=0x0100, rsp_cout=0; rsp_valid 5 cycles after accept.
REQ-034 SUBU 0x1000-0x0001 -> lo slice alu_cin=1, hi slice alu_cin=0; rsp_result=0x0FFF, rsp_cout=1.
REQ-035 XOR 0xA5A5^0xFFFF -> alu_cin=0 on both slices; rsp_result=0x5A5A.
REQ-036 Backpressure: alu_ready low 3 cycles in ISSUE_LO, rsp_ready low 2 cycles in RESP -> ALU and response outputs stable, req_ready=0 throughout, single op_count increment.
REQ-037 Reset asserted in WAIT_HI, then alu_rsp_valid pulse in IDLE -> no rsp_valid, proto_err=1, op_count unchanged at 0.
REQ-038 256 ADDU 0xFFFF+0x0001 ops -> each rsp_result=0x0000, rsp_cout=1; op_count wraps to 0x00.
